// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared write-selector encodings and commit-stage state encoding
package core_pkg;

    localparam int WSEL_FLT = 0;
    localparam int WSEL_REG = 1;
    localparam int WSEL_PC  = 2;

    localparam logic [2:0] WSEL_NONE = 3'b000;
    localparam logic [2:0] WSEL_GPR  = 3'b010;
    localparam logic [2:0] WSEL_FPR  = 3'b011;
    localparam logic [2:0] WSEL_BR   = 3'b100;
    localparam logic [2:0] WSEL_LINK = 3'b110;

    typedef enum logic {
        WB_IDLE   = 1'b0,
        WB_COMMIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32x32 register file, two async read ports, one sync write port
module regfile_2r1w #(
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);

    // Contents are deliberately unreset; r0 is forced on the read side only.
    logic [31:0] mem_q [32];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (ZERO_R0 && raddr_a_i == 5'd0) ? 32'd0 : mem_q[raddr_a_i];
    assign rdata_b_o = (ZERO_R0 && raddr_b_i == 5'd0) ? 32'd0 : mem_q[raddr_b_i];

endmodule

// File: rtl/write_back.sv
// rtl/write_back.sv - commit stage: register-file writes, architectural PC, retire count, read bypass
module write_back
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             stall_enable,
    input  logic [2:0]       wselector,
    input  logic [31:0]      data,
    input  logic [4:0]       rd,
    input  logic [31:0]      pc_in,
    input  logic [4:0]       rs_no,
    input  logic [4:0]       rt_no,
    input  logic             fmode1,
    input  logic             fmode2,
    output logic [31:0]      rs,
    output logic [31:0]      rt,
    output logic [31:0]      pc,
    output logic             done,
    output logic [CNT_W-1:0] retired,
    output logic             overrun
);

    wb_state_e        state_q, state_d;
    logic             squash_q;
    logic [2:0]       wsel_q;
    logic [31:0]      data_q;
    logic [4:0]       rd_q;
    logic [29:0]      pcin_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] retired_q;
    logic             done_q;
    logic             overrun_q;

    logic             commit;
    logic             gpr_we, fpr_we;
    logic [31:0]      gpr_a, gpr_b, fpr_a, fpr_b;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        gpr_we  = 1'b0;
        fpr_we  = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (enable) state_d = WB_COMMIT;
            end
            WB_COMMIT: begin
                state_d = WB_IDLE;
                commit  = 1'b1;
                gpr_we  = !squash_q && wsel_q[WSEL_REG] && !wsel_q[WSEL_FLT] && rd_q != 5'd0;
                fpr_we  = !squash_q && wsel_q[WSEL_REG] && wsel_q[WSEL_FLT];
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            squash_q  <= 1'b0;
            wsel_q    <= 3'b000;
            data_q    <= 32'd0;
            rd_q      <= 5'd0;
            pcin_q    <= 30'd0;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= commit;
            if (state_q == WB_IDLE && enable) begin
                squash_q <= stall_enable;
                wsel_q   <= wselector;
                data_q   <= data;
                rd_q     <= rd;
                pcin_q   <= pc_in[31:2];
            end
            if (state_q == WB_COMMIT && enable) begin
                overrun_q <= 1'b1;
            end
            // A squashed instruction still handshakes with fetch but leaves no trace.
            if (commit && !squash_q) begin
                pc_q      <= wsel_q[WSEL_PC] ? {pcin_q, 2'b00} : pc_q + 32'd4;
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    regfile_2r1w #(.ZERO_R0(1'b1)) u_gpr (
        .clk       (clk),
        .we_i      (gpr_we),
        .waddr_i   (rd_q),
        .wdata_i   (data_q),
        .raddr_a_i (rs_no),
        .raddr_b_i (rt_no),
        .rdata_a_o (gpr_a),
        .rdata_b_o (gpr_b)
    );

    regfile_2r1w #(.ZERO_R0(1'b0)) u_fpr (
        .clk       (clk),
        .we_i      (fpr_we),
        .waddr_i   (rd_q),
        .wdata_i   (data_q),
        .raddr_a_i (rs_no),
        .raddr_b_i (rt_no),
        .rdata_a_o (fpr_a),
        .rdata_b_o (fpr_b)
    );

    // gpr_we already excludes r0, so the bypass can never shadow the hard zero.
    always_comb begin
        rs = fmode1 ? ((fpr_we && rs_no == rd_q) ? data_q : fpr_a)
                    : ((gpr_we && rs_no == rd_q) ? data_q : gpr_a);
        rt = fmode2 ? ((fpr_we && rt_no == rd_q) ? data_q : fpr_b)
                    : ((gpr_we && rt_no == rd_q) ? data_q : gpr_b);
    end

    assign pc      = pc_q;
    assign done    = done_q;
    assign retired = retired_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - directed self-checking bench for write_back
module tb_write_back;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        stall_enable = 1'b0;
    logic [2:0]  wselector = 3'b000;
    logic [31:0] data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] pc_in = 32'd0;
    logic [4:0]  rs_no = 5'd0;
    logic [4:0]  rt_no = 5'd0;
    logic        fmode1 = 1'b0;
    logic        fmode2 = 1'b0;
    logic [31:0] rs, rt, pc;
    logic        done;
    logic [31:0] retired;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    write_back #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .stall_enable (stall_enable),
        .wselector    (wselector),
        .data         (data),
        .rd           (rd),
        .pc_in        (pc_in),
        .rs_no        (rs_no),
        .rt_no        (rt_no),
        .fmode1       (fmode1),
        .fmode2       (fmode2),
        .rs           (rs),
        .rt           (rt),
        .pc           (pc),
        .done         (done),
        .retired      (retired),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic drive_op(input logic sq, input logic [2:0] ws, input logic [4:0] r,
                            input logic [31:0] d, input logic [31:0] tgt);
        stall_enable = sq;
        wselector    = ws;
        rd           = r;
        data         = d;
        pc_in        = tgt;
    endtask

    // Ends #1 after the commit edge, where done should be high.
    task automatic do_commit(input logic sq, input logic [2:0] ws, input logic [4:0] r,
                             input logic [31:0] d, input logic [31:0] tgt);
        @(posedge clk); #1;
        drive_op(sq, ws, r, d, tgt);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic read_rs(input logic [4:0] n, input logic f);
        rs_no  = n;
        fmode1 = f;
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        read_rs(5'd0, 1'b0);
        checks++; if (rs !== 32'h0) begin errors++; $display("FAIL reset_r0 got %h want 0", rs); end
        rstn = 1'b1;
    endtask

    task automatic test_gpr_write;
        do_commit(1'b0, 3'b010, 5'd5, 32'hDEADBEEF, 32'h0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gpr_done got %b want 1", done); end
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL gpr_pc got %h want 4", pc); end
        checks++; if (retired !== 32'd1) begin errors++; $display("FAIL gpr_retired got %0d want 1", retired); end
        read_rs(5'd5, 1'b0);
        checks++; if (rs !== 32'hDEADBEEF) begin errors++; $display("FAIL gpr_r5 got %h want deadbeef", rs); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL gpr_done_pulse got %b want 0", done); end
    endtask

    task automatic test_zero_regs;
        do_commit(1'b0, 3'b010, 5'd0, 32'h1234, 32'h0);
        do_commit(1'b0, 3'b011, 5'd0, 32'h3F800000, 32'h0);
        read_rs(5'd0, 1'b0);
        checks++; if (rs !== 32'h0) begin errors++; $display("FAIL r0_zero got %h want 0", rs); end
        read_rs(5'd0, 1'b1);
        checks++; if (rs !== 32'h3F800000) begin errors++; $display("FAIL f0_write got %h want 3f800000", rs); end
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL zero_pc got %h want c", pc); end
    endtask

    task automatic test_link;
        do_commit(1'b0, 3'b100, 5'd0, 32'h0, 32'h100);
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL br_pc got %h want 100", pc); end
        do_commit(1'b0, 3'b110, 5'd31, 32'h104, 32'h203);
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL link_pc got %h want 200", pc); end
        read_rs(5'd31, 1'b0);
        checks++; if (rs !== 32'h104) begin errors++; $display("FAIL link_r31 got %h want 104", rs); end
        do_commit(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        checks++; if (pc !== 32'h204) begin errors++; $display("FAIL none_pc got %h want 204", pc); end
        checks++; if (retired !== 32'd6) begin errors++; $display("FAIL link_retired got %0d want 6", retired); end
    endtask

    task automatic test_squash;
        do_commit(1'b0, 3'b010, 5'd3, 32'h33, 32'h0);
        do_commit(1'b1, 3'b010, 5'd3, 32'hBAD, 32'h0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL squash_done got %b want 1", done); end
        checks++; if (pc !== 32'h208) begin errors++; $display("FAIL squash_pc got %h want 208", pc); end
        checks++; if (retired !== 32'd7) begin errors++; $display("FAIL squash_retired got %0d want 7", retired); end
        read_rs(5'd3, 1'b0);
        checks++; if (rs !== 32'h33) begin errors++; $display("FAIL squash_r3 got %h want 33", rs); end
    endtask

    task automatic test_bypass;
        do_commit(1'b0, 3'b011, 5'd7, 32'h11111111, 32'h0);
        @(posedge clk); #1;
        drive_op(1'b0, 3'b010, 5'd7, 32'hA5A5A5A5, 32'h0);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        rt_no  = 5'd7;
        fmode2 = 1'b0;
        read_rs(5'd7, 1'b0);
        checks++; if (rs !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_gpr got %h want a5a5a5a5", rs); end
        checks++; if (rt !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_gpr_rt got %h want a5a5a5a5", rt); end
        read_rs(5'd7, 1'b1);
        checks++; if (rs !== 32'h11111111) begin errors++; $display("FAIL byp_fpr_old got %h want 11111111", rs); end
        @(posedge clk); #1;
        read_rs(5'd7, 1'b0);
        checks++; if (rs !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_committed got %h want a5a5a5a5", rs); end
        checks++; if (pc !== 32'h210) begin errors++; $display("FAIL byp_pc got %h want 210", pc); end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        drive_op(1'b0, 3'b010, 5'd8, 32'h88, 32'h0);
        enable = 1'b1;
        @(posedge clk); #1;
        drive_op(1'b0, 3'b010, 5'd9, 32'h99, 32'h0);
        @(posedge clk); #1;
        enable = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (retired !== 32'd10) begin errors++; $display("FAIL ovr_retired got %0d want 10", retired); end
        checks++; if (pc !== 32'h214) begin errors++; $display("FAIL ovr_pc got %h want 214", pc); end
        read_rs(5'd8, 1'b0);
        checks++; if (rs !== 32'h88) begin errors++; $display("FAIL ovr_r8 got %h want 88", rs); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_pc_wrap;
        do_commit(1'b0, 3'b100, 5'd0, 32'h0, 32'hFFFFFFFF);
        checks++; if (pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_align got %h want fffffffc", pc); end
        do_commit(1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc); end
        checks++; if (retired !== 32'd12) begin errors++; $display("FAIL wrap_retired got %0d want 12", retired); end
    endtask

    task automatic test_reset_mid_commit;
        do_commit(1'b0, 3'b010, 5'd10, 32'h10, 32'h0);
        @(posedge clk); #1;
        drive_op(1'b0, 3'b110, 5'd10, 32'hBAD, 32'h400);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        rstn = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rmid_pc got %h want 0", pc); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rmid_retired got %0d want 0", retired); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %b want 0", overrun); end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        read_rs(5'd10, 1'b0);
        checks++; if (rs !== 32'h10) begin errors++; $display("FAIL rmid_r10 got %h want 10", rs); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rmid_pc_after got %h want 0", pc); end
    endtask

    initial begin
        test_reset();
        test_gpr_write();
        test_zero_regs();
        test_link();
        test_squash();
        test_bypass();
        test_back_to_back();
        test_pc_wrap();
        test_reset_mid_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
